// File: rtl/ru_pkg.sv
// Shared register-unit types for the RU write arbiter.
// The optional busy scoreboard is built only when RU_ARB_SCOREBOARD_EN is defined.
package ru_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int NUM_REQ    = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } ru_wr_req_t;

  typedef enum logic {PRI0 = 1'b0, PRI1 = 1'b1} pri_state_t;

  // Writes to x0 are accepted but never reach the register file.
  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] rd);
    return rd == '0;
  endfunction
endpackage

// File: rtl/ru_wr_arbiter_if.sv
// Requester / RU write-port bundle for ru_wr_arbiter.
// Scoreboard signals exist only when RU_ARB_SCOREBOARD_EN is defined.
interface ru_wr_arbiter_if import ru_pkg::*; ();
  logic                  req0_valid;
  logic [REG_ADDR_W-1:0] req0_rd;
  logic [XLEN-1:0]       req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [REG_ADDR_W-1:0] req1_rd;
  logic [XLEN-1:0]       req1_data;
  logic                  req1_ready;
  logic                  RUWr;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       DataWr;
  logic                  grant_id;
`ifdef RU_ARB_SCOREBOARD_EN
  logic                  rsv_valid;
  logic [REG_ADDR_W-1:0] rsv_rd;
  logic [REG_ADDR_W-1:0] chk_rs1;
  logic [REG_ADDR_W-1:0] chk_rs2;
  logic                  busy_rs1;
  logic                  busy_rs2;

  modport master (
    output req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
    output rsv_valid, rsv_rd, chk_rs1, chk_rs2,
    input  req0_ready, req1_ready, RUWr, rd, DataWr, grant_id, busy_rs1, busy_rs2
  );
  modport slave (
    input  req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
    input  rsv_valid, rsv_rd, chk_rs1, chk_rs2,
    output req0_ready, req1_ready, RUWr, rd, DataWr, grant_id, busy_rs1, busy_rs2
  );
`else
  modport master (
    output req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready, RUWr, rd, DataWr, grant_id
  );
  modport slave (
    input  req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready, RUWr, rd, DataWr, grant_id
  );
`endif
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: holder of priority wins a tie, a lone
// requester always wins, and priority flips to the other side after a grant.
module rr_arb2 import ru_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  pri_state_t state;

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req == 2'b11) gnt = (state == PRI0) ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          state <= PRI0;
    else if (advance) state <= gnt[0] ? PRI1 : PRI0;
  end
endmodule

// File: rtl/ru_wr_arbiter.sv
// Arbitrates two writeback requesters onto the single RU write port, 1-cycle latency.
// Define RU_ARB_SCOREBOARD_EN to add the per-register busy scoreboard.
module ru_wr_arbiter import ru_pkg::*; (
  input logic           Clk,
  input logic           Rst,
  ru_wr_arbiter_if.slave bus
);
  ru_wr_req_t [NUM_REQ-1:0] req;
  logic       [NUM_REQ-1:0] vld;
  logic       [NUM_REQ-1:0] gnt;
  ru_wr_req_t               sel;
  logic                     accepted;

  logic                  wr_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       data_q;
  logic                  gid_q;

  assign req[0] = {bus.req0_rd, bus.req0_data};
  assign req[1] = {bus.req1_rd, bus.req1_data};
  assign vld    = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_arb (
    .clk     (Clk),
    .rst     (Rst),
    .req     (vld),
    .advance (accepted),
    .gnt     (gnt)
  );

  // Ready only depends on valid, so a grant is always an acceptance.
  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign accepted       = |gnt;
  assign sel            = gnt[1] ? req[1] : req[0];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      gid_q  <= 1'b0;
    end else if (accepted && !is_x0(sel.rd)) begin
      wr_q   <= 1'b1;
      rd_q   <= sel.rd;
      data_q <= sel.data;
      gid_q  <= gnt[1];
    end else begin
      wr_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      if (accepted) gid_q <= gnt[1];
    end
  end

  // A write accepted just before reset must not reach the RU during reset.
  assign bus.RUWr     = wr_q & ~Rst;
  assign bus.rd       = Rst ? '0 : rd_q;
  assign bus.DataWr   = Rst ? '0 : data_q;
  assign bus.grant_id = gid_q;

`ifdef RU_ARB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy;

  // Later assignment wins, so a reservation beats a same-edge commit.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      busy <= '0;
    end else begin
      if (bus.RUWr) busy[bus.rd] <= 1'b0;
      if (bus.rsv_valid) busy[bus.rsv_rd] <= 1'b1;
      busy[0] <= 1'b0;
    end
  end

  assign bus.busy_rs1 = busy[bus.chk_rs1];
  assign bus.busy_rs2 = busy[bus.chk_rs2];
`endif
endmodule

// File: tb/tb_ru_wr_arbiter.sv
// Directed bench for ru_wr_arbiter; scoreboard scenario runs when RU_ARB_SCOREBOARD_EN is defined.
module tb_ru_wr_arbiter;
  import ru_pkg::*;

  logic Clk = 1'b0;
  logic Rst;
  int   n_cmp = 0;
  int   n_err = 0;

  ru_wr_arbiter_if bus();

  ru_wr_arbiter dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.req0_valid = 0; bus.req0_rd = 0; bus.req0_data = 0;
    bus.req1_valid = 0; bus.req1_rd = 0; bus.req1_data = 0;
  endtask

  task automatic test_reset();
    Rst = 1;
    idle();
`ifdef RU_ARB_SCOREBOARD_EN
    bus.rsv_valid = 0; bus.rsv_rd = 0; bus.chk_rs1 = 0; bus.chk_rs2 = 0;
`endif
    tick(); tick();
    bus.req0_valid = 1; bus.req1_valid = 1;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_rdy0 got %b want 0", bus.req0_ready); end
    n_cmp++; if (bus.req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_rdy1 got %b want 0", bus.req1_ready); end
    n_cmp++; if (bus.RUWr !== 1'b0) begin n_err++; $display("FAIL reset_ruwr got %b want 0", bus.RUWr); end
    n_cmp++; if (bus.rd !== 5'd0) begin n_err++; $display("FAIL reset_rd got %0d want 0", bus.rd); end
    n_cmp++; if (bus.DataWr !== 32'd0) begin n_err++; $display("FAIL reset_data got %0d want 0", bus.DataWr); end
    n_cmp++; if (bus.grant_id !== 1'b0) begin n_err++; $display("FAIL reset_gid got %b want 0", bus.grant_id); end
    tick();
    idle();
    Rst = 0;
    tick();
  endtask

  task automatic test_single();
    bus.req0_valid = 1; bus.req0_rd = 5; bus.req0_data = 45;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL single_rdy0 got %b want 1", bus.req0_ready); end
    n_cmp++; if (bus.req1_ready !== 1'b0) begin n_err++; $display("FAIL single_rdy1 got %b want 0", bus.req1_ready); end
    tick();
    idle();
    n_cmp++; if (bus.RUWr !== 1'b1) begin n_err++; $display("FAIL single_ruwr got %b want 1", bus.RUWr); end
    n_cmp++; if (bus.rd !== 5'd5) begin n_err++; $display("FAIL single_rd got %0d want 5", bus.rd); end
    n_cmp++; if (bus.DataWr !== 32'd45) begin n_err++; $display("FAIL single_data got %0d want 45", bus.DataWr); end
    n_cmp++; if (bus.grant_id !== 1'b0) begin n_err++; $display("FAIL single_gid got %b want 0", bus.grant_id); end
    tick();
    n_cmp++; if (bus.RUWr !== 1'b0) begin n_err++; $display("FAIL single_idle_ruwr got %b want 0", bus.RUWr); end
    n_cmp++; if (bus.DataWr !== 32'd0) begin n_err++; $display("FAIL single_idle_data got %0d want 0", bus.DataWr); end
  endtask

  task automatic test_contention();
    Rst = 1; tick(); Rst = 0;
    bus.req0_valid = 1; bus.req0_rd = 10; bus.req0_data = 100;
    bus.req1_valid = 1; bus.req1_rd = 11; bus.req1_data = 200;
    #1;
    n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_err++; $display("FAIL cont_rdy_a got %b want 01", {bus.req1_ready, bus.req0_ready}); end
    tick();
    bus.req0_valid = 0;
    n_cmp++; if ({bus.RUWr, bus.rd, bus.DataWr, bus.grant_id} !== {1'b1, 5'd10, 32'd100, 1'b0}) begin n_err++; $display("FAIL cont_wr_a got ruwr=%b rd=%0d data=%0d gid=%b want 1/10/100/0", bus.RUWr, bus.rd, bus.DataWr, bus.grant_id); end
    #1;
    n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin n_err++; $display("FAIL cont_rdy_b got %b want 10", {bus.req1_ready, bus.req0_ready}); end
    tick();
    bus.req1_valid = 0;
    n_cmp++; if ({bus.RUWr, bus.rd, bus.DataWr, bus.grant_id} !== {1'b1, 5'd11, 32'd200, 1'b1}) begin n_err++; $display("FAIL cont_wr_b got ruwr=%b rd=%0d data=%0d gid=%b want 1/11/200/1", bus.RUWr, bus.rd, bus.DataWr, bus.grant_id); end
    tick();
    n_cmp++; if ({bus.RUWr, bus.rd, bus.grant_id} !== {1'b0, 5'd0, 1'b1}) begin n_err++; $display("FAIL cont_hold got ruwr=%b rd=%0d gid=%b want 0/0/1", bus.RUWr, bus.rd, bus.grant_id); end
  endtask

  task automatic test_round_robin();
    logic [1:0] prev = 2'b00;
    logic [1:0] exp_rdy;
    bus.req0_valid = 1; bus.req0_rd = 1; bus.req0_data = 32'h11;
    bus.req1_valid = 1; bus.req1_rd = 2; bus.req1_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== exp_rdy) begin n_err++; $display("FAIL rr_rdy[%0d] got %b want %b", k, {bus.req1_ready, bus.req0_ready}, exp_rdy); end
      n_cmp++; if ((prev & {bus.req1_ready, bus.req0_ready}) !== 2'b00) begin n_err++; $display("FAIL rr_repeat[%0d] got prev=%b now=%b want no overlap", k, prev, {bus.req1_ready, bus.req0_ready}); end
      prev = {bus.req1_ready, bus.req0_ready};
      tick();
      n_cmp++; if ({bus.RUWr, bus.grant_id, bus.rd} !== {1'b1, exp_rdy[1], exp_rdy[1] ? 5'd2 : 5'd1}) begin n_err++; $display("FAIL rr_wr[%0d] got ruwr=%b gid=%b rd=%0d want gid=%b", k, bus.RUWr, bus.grant_id, bus.rd, exp_rdy[1]); end
    end
    idle();
    tick();
  endtask

  task automatic test_x0();
    bus.req1_valid = 1; bus.req1_rd = 0; bus.req1_data = 123;
    #1;
    n_cmp++; if (bus.req1_ready !== 1'b1) begin n_err++; $display("FAIL x0_rdy1 got %b want 1", bus.req1_ready); end
    tick();
    idle();
    n_cmp++; if ({bus.RUWr, bus.rd, bus.DataWr} !== {1'b0, 5'd0, 32'd0}) begin n_err++; $display("FAIL x0_wr got ruwr=%b rd=%0d data=%0d want 0/0/0", bus.RUWr, bus.rd, bus.DataWr); end
    // x0 grant to req0 must still rotate priority so req1 wins the next tie.
    bus.req0_valid = 1; bus.req0_rd = 0; bus.req0_data = 77;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL x0_rdy0 got %b want 1", bus.req0_ready); end
    tick();
    n_cmp++; if (bus.RUWr !== 1'b0) begin n_err++; $display("FAIL x0_wr0 got %b want 0", bus.RUWr); end
    bus.req0_rd = 3; bus.req0_data = 33;
    bus.req1_valid = 1; bus.req1_rd = 4; bus.req1_data = 44;
    #1;
    n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin n_err++; $display("FAIL x0_rotate got %b want 10", {bus.req1_ready, bus.req0_ready}); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_midop();
    bus.req0_valid = 1; bus.req0_rd = 7; bus.req0_data = 9;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL mid_rdy got %b want 1", bus.req0_ready); end
    tick();
    Rst = 1;
    bus.req1_valid = 1; bus.req1_rd = 8; bus.req1_data = 10;
    #1;
    n_cmp++; if ({bus.RUWr, bus.rd, bus.DataWr} !== {1'b0, 5'd0, 32'd0}) begin n_err++; $display("FAIL mid_drop got ruwr=%b rd=%0d data=%0d want 0/0/0", bus.RUWr, bus.rd, bus.DataWr); end
    n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_err++; $display("FAIL mid_rdy_rst got %b want 00", {bus.req1_ready, bus.req0_ready}); end
    tick();
    Rst = 0;
    #1;
    n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_err++; $display("FAIL mid_pri0 got %b want 01", {bus.req1_ready, bus.req0_ready}); end
    tick();
    idle();
    n_cmp++; if ({bus.RUWr, bus.rd, bus.grant_id} !== {1'b1, 5'd7, 1'b0}) begin n_err++; $display("FAIL mid_after got ruwr=%b rd=%0d gid=%b want 1/7/0", bus.RUWr, bus.rd, bus.grant_id); end
    tick();
  endtask

`ifdef RU_ARB_SCOREBOARD_EN
  task automatic test_scoreboard();
    bus.rsv_valid = 1; bus.rsv_rd = 5; bus.chk_rs1 = 5; bus.chk_rs2 = 0;
    tick();
    bus.rsv_valid = 1; bus.rsv_rd = 0;
    tick();
    bus.rsv_valid = 0;
    n_cmp++; if (bus.busy_rs1 !== 1'b1) begin n_err++; $display("FAIL sb_set got %b want 1", bus.busy_rs1); end
    n_cmp++; if (bus.busy_rs2 !== 1'b0) begin n_err++; $display("FAIL sb_x0 got %b want 0", bus.busy_rs2); end
    bus.req0_valid = 1; bus.req0_rd = 5; bus.req0_data = 55;
    tick();
    idle();
    n_cmp++; if (bus.busy_rs1 !== 1'b1) begin n_err++; $display("FAIL sb_during_wr got %b want 1", bus.busy_rs1); end
    tick();
    n_cmp++; if (bus.busy_rs1 !== 1'b0) begin n_err++; $display("FAIL sb_clear got %b want 0", bus.busy_rs1); end
    bus.rsv_valid = 1; bus.rsv_rd = 5;
    tick();
    bus.rsv_valid = 0;
    bus.req0_valid = 1; bus.req0_rd = 5; bus.req0_data = 56;
    tick();
    idle();
    bus.rsv_valid = 1; bus.rsv_rd = 5;
    tick();
    bus.rsv_valid = 0;
    n_cmp++; if (bus.busy_rs1 !== 1'b1) begin n_err++; $display("FAIL sb_set_wins got %b want 1", bus.busy_rs1); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_x0();
    test_reset_midop();
`ifdef RU_ARB_SCOREBOARD_EN
    test_scoreboard();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ru_wr_arbiter.md
RU_WR_ARBITER -- requirements
Module: ru_wr_arbiter

Interface
REQ-001 SHALL have ports: Clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: Rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: req0_valid  in  1 / req0_rd  in  5 / req0_data  in  32  requester 0 (ALU writeback) write request.
REQ-004 SHALL have: req0_ready  out  1  requester 0 accept strobe.
REQ-005 SHALL have: req1_valid  in  1 / req1_rd  in  5 / req1_data  in  32 / req1_ready  out  1  requester 1 (load/multi-cycle unit).
REQ-006 SHALL have: RUWr  out  1 / rd  out  5 / DataWr  out  32  RegistersUnit write port.
REQ-007 SHALL have: grant_id  out  1  requester that sourced the current RU write.
REQ-008 SHALL have, only with RU_ARB_SCOREBOARD_EN: rsv_valid  in  1 / rsv_rd  in  5 (reservation); chk_rs1, chk_rs2  in  5; busy_rs1, busy_rs2  out  1.

Function
REQ-009 SHALL accept a transfer on requester i when reqi_valid and reqi_ready are both high at a rising edge.
REQ-010 SHALL drive reqi_ready combinationally; high only for the selected requester; never both high.
REQ-011 SHALL keep 2-state priority FSM PRI0/PRI1; holder wins when both valid.
REQ-012 SHALL move to PRI1 after a grant to 0, and to PRI0 after a grant to 1; no grant -> state unchanged.
REQ-013 SHALL grant a lone valid requester in the same cycle regardless of priority state.
REQ-014 SHALL present an accepted write on RUWr/rd/DataWr/grant_id in cycle N+1 (1-cycle latency) for exactly one cycle.
REQ-015 SHALL, with no acceptance in cycle N, drive RUWr=0, rd=0, DataWr=0 in N+1; grant_id holds.
REQ-016 SHALL accept requests with rd=0 (ready high, priority rotates) but drive RUWr=0, rd=0, DataWr=0 in N+1.
REQ-017 SHALL sustain one accepted write per cycle; back-to-back grants allowed.
REQ-018 SHALL rely on requesters holding valid/rd/data stable until accepted; no internal request buffering.

Reset
REQ-019 SHALL, while Rst high, force req0_ready=req1_ready=0.
REQ-020 SHALL, on the edge with Rst high, set RUWr=0, rd=0, DataWr=0, grant_id=0, FSM=PRI0, busy vector all 0.
REQ-021 SHALL drop a write accepted in the cycle before Rst asserts (RUWr=0 in the Rst cycle).

Configuration
REQ-022 SHALL, with RU_ARB_SCOREBOARD_EN defined, keep a 32-bit busy vector; bit 0 constant 0.
REQ-023 SHALL set busy[rsv_rd] on an edge with rsv_valid high (rsv_rd=0 ignored).
REQ-024 SHALL clear busy[rd] on the edge ending a cycle with RUWr=1.
REQ-025 SHALL give set priority over clear when both hit the same index on one edge.
REQ-026 SHALL drive busy_rsX = busy[chk_rsX] combinationally.
REQ-027 SHALL, without RU_ARB_SCOREBOARD_EN, omit the REQ-008 ports and the busy vector; all other behaviour identical.

Structure
REQ-028 SHALL take XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and a packed typedef ru_wr_req_t {rd, data} from shared package ru_pkg.
REQ-029 SHALL put the 2-way round-robin selection in sub-module rr_arb2 (inputs req[1:0], advance; outputs gnt[1:0]).

Verification
REQ-030 Single request: req0 valid rd=5 data=45 -> req0_ready=1 same cycle; next cycle RUWr=1 rd=5 DataWr=45 grant_id=0.
REQ-031 Contention: both valid from reset (req0 rd=10 data=100, req1 rd=11 data=200) -> req0 first, req1 next cycle; RU writes x10=100 then x11=200 on consecutive cycles.
REQ-032 Round-robin: both held valid 4 cycles -> grant_id sequence 0,1,0,1; neither ready high twice in a row.
REQ-033 x0 write: req1 rd=0 data=123 -> req1_ready=1; next cycle RUWr=0; register x0 reads 0.
REQ-034 Reset mid-op: req0 accepted rd=7, Rst high next cycle -> RUWr=0, FSM=PRI0, ready outputs 0 during Rst.
REQ-035 Scoreboard (macro on): rsv rd=5, chk_rs1=5 -> busy_rs1=1; req0 writes x5 -> busy_rs1=0 after the RUWr cycle; reserve and commit x5 on the same edge -> busy_rs1 stays 1.
